// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift right/left, parallel load, with a word-completion counter.
// Latency: one cycle; a mode applied before edge N is visible on o_q after edge N.
// Backpressure: none; i_en=0 freezes all state, there is no handshake.
//
// Ports:
//   i_clk, i_rst       clock and synchronous active-high reset
//   i_en               clock enable (0 holds q and the shift count)
//   i_mode             00 hold, 01 shift right, 10 shift left, 11 parallel load
//   i_d                parallel load data
//   i_sin_r, i_sin_l   serial inputs entering the MSB (right shift) / LSB (left shift)
//   i_rot              rotate select, only present when ROTATE_EN is defined
//   o_q, o_nq          register contents and their complement
//   o_sout_r, o_sout_l bits leaving on a right / left shift
//   o_word_done        one-cycle pulse after WIDTH shifts since last load, reset or wrap
// Optional feature macro: ROTATE_EN (adds i_rot and end-around rotation).
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin_r,
    input  logic             i_sin_l,
`ifdef ROTATE_EN
    input  logic             i_rot,
`endif
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_nq,
    output logic             o_sout_r,
    output logic             o_sout_l,
    output logic             o_word_done
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_word_done;

    logic             w_in_r;
    logic             w_in_l;
    logic [WIDTH-1:0] w_q_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_done_next;
    logic             w_shift;

    // Serial entry bits; with rotation the bit leaving one end re-enters the other.
`ifdef ROTATE_EN
    assign w_in_r = i_rot ? r_q[0]       : i_sin_r;
    assign w_in_l = i_rot ? r_q[WIDTH-1] : i_sin_l;
`else
    assign w_in_r = i_sin_r;
    assign w_in_l = i_sin_l;
`endif

    always_comb begin
        w_q_next    = r_q;
        w_cnt_next  = r_cnt;
        w_done_next = 1'b0;
        w_shift     = 1'b0;
        if (i_en) begin
            case (i_mode)
                MODE_RIGHT: begin
                    w_q_next = {w_in_r, r_q[WIDTH-1:1]};
                    w_shift  = 1'b1;
                end
                MODE_LEFT: begin
                    w_q_next = {r_q[WIDTH-2:0], w_in_l};
                    w_shift  = 1'b1;
                end
                MODE_LOAD: begin
                    w_q_next   = i_d;
                    w_cnt_next = '0;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
            // Both directions feed one counter; the WIDTH-th shift wraps it and flags the word.
            if (w_shift) begin
                if (r_cnt == LAST) begin
                    w_cnt_next  = '0;
                    w_done_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q         <= '0;
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_q         <= w_q_next;
            r_cnt       <= w_cnt_next;
            r_word_done <= w_done_next;
        end
    end

    assign o_q         = r_q;
    assign o_nq        = ~r_q;
    assign o_sout_r    = r_q[0];
    assign o_sout_l    = r_q[WIDTH-1];
    assign o_word_done = r_word_done;

endmodule
